// File: rtl/bridge_router.sv
// Host bridge address router: registered decode to one of NUM_LEAVES leaf agents,
// with optional base strip / byte swap and a fixed-latency in-order read return.
module bridge_router #(
   parameter int                            NUM_LEAVES    = 4,
   parameter int                            ADDR_W        = 32,
   parameter int                            DATA_W        = 32,
   parameter logic [NUM_LEAVES*ADDR_W-1:0]  ADDR_FROM     = '0,
   parameter logic [NUM_LEAVES*ADDR_W-1:0]  ADDR_TO       = '0,
   parameter logic [NUM_LEAVES-1:0]         STRIP_BASE    = '0,
   parameter logic [NUM_LEAVES-1:0]         SWAP_BYTES    = '0,
   parameter int                            LEAF_LATENCY  = 1,
   parameter logic [DATA_W-1:0]             DEFAULT_RDATA = 32'hFFFF_FFFF
) (
   input  logic                            clk_74a,
   input  logic                            reset,
   input  logic [ADDR_W-1:0]               in_addr,
   input  logic                            in_wr,
   input  logic                            in_rd,
   input  logic [DATA_W-1:0]               in_wr_data,
   output logic [DATA_W-1:0]               in_rd_data,
   output logic                            in_rd_valid,
   output logic [NUM_LEAVES*ADDR_W-1:0]    out_addr,
   output logic [NUM_LEAVES-1:0]           out_wr,
   output logic [NUM_LEAVES-1:0]           out_rd,
   output logic [NUM_LEAVES*DATA_W-1:0]    out_wr_data,
   input  logic [NUM_LEAVES*DATA_W-1:0]    out_rd_data,
   output logic [15:0]                     unmapped_count
);

   localparam int IDX_W = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;
   localparam int NB    = DATA_W / 8;
   localparam int LAT   = LEAF_LATENCY;

   function automatic logic [DATA_W-1:0] swap_bytes(input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int b = 0; b < NB; b++) r[b*8 +: 8] = d[(NB-1-b)*8 +: 8];
      return r;
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
      logic [16:0] s;
      s = {1'b0, c} + {15'd0, inc};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   logic                          hit_any;
   logic [IDX_W-1:0]              hit_idx;
   logic                          rd_go;
   logic [1:0]                    cnt_inc;

   logic [NUM_LEAVES-1:0]         out_wr_d, out_wr_q, out_rd_d, out_rd_q;
   logic [NUM_LEAVES*ADDR_W-1:0]  out_addr_d, out_addr_q;
   logic [NUM_LEAVES*DATA_W-1:0]  out_wr_data_d, out_wr_data_q;
   logic [15:0]                   unmapped_cnt_d, unmapped_cnt_q;

   logic                          s1_vld_d, s1_vld_q, s1_unm_d, s1_unm_q;
   logic [IDX_W-1:0]              s1_idx_d, s1_idx_q;

   logic [LAT-1:0]                pipe_vld_d, pipe_vld_q, pipe_unm_d, pipe_unm_q;
   logic [LAT-1:0][IDX_W-1:0]     pipe_idx_d, pipe_idx_q;

   logic [IDX_W-1:0]              exit_idx;
   logic [DATA_W-1:0]             leaf_word;
   logic                          rd_valid_d, rd_valid_q;
   logic [DATA_W-1:0]             rd_data_d, rd_data_q;

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
         if (in_addr >= ADDR_FROM[i*ADDR_W +: ADDR_W] && in_addr <= ADDR_TO[i*ADDR_W +: ADDR_W]) begin
            hit_any = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Stage 1: leaf strobes, address/data capture, unmapped/dropped accounting
   always_comb begin
      rd_go         = in_rd & ~in_wr;
      out_wr_d      = '0;
      out_rd_d      = '0;
      out_addr_d    = out_addr_q;
      out_wr_data_d = out_wr_data_q;
      if (hit_any && (in_wr || rd_go)) begin
         out_addr_d[hit_idx*ADDR_W +: ADDR_W] = STRIP_BASE[hit_idx]
            ? in_addr - ADDR_FROM[hit_idx*ADDR_W +: ADDR_W] : in_addr;
         if (in_wr) begin
            out_wr_d[hit_idx] = 1'b1;
            out_wr_data_d[hit_idx*DATA_W +: DATA_W] = SWAP_BYTES[hit_idx]
               ? swap_bytes(in_wr_data) : in_wr_data;
         end else begin
            out_rd_d[hit_idx] = 1'b1;
         end
      end
      cnt_inc = {1'b0, in_wr & ~hit_any} + {1'b0, rd_go & ~hit_any} + {1'b0, in_rd & in_wr};
      unmapped_cnt_d = sat_add(unmapped_cnt_q, cnt_inc);
      s1_vld_d = rd_go;
      s1_idx_d = hit_idx;
      s1_unm_d = ~hit_any;
   end

   // Read tag pipeline, then return-data capture at the leaf sampling edge
   always_comb begin
      pipe_vld_d[0] = s1_vld_q;
      pipe_unm_d[0] = s1_unm_q;
      pipe_idx_d[0] = s1_idx_q;
      for (int k = 1; k < LAT; k++) begin
         pipe_vld_d[k] = pipe_vld_q[k-1];
         pipe_unm_d[k] = pipe_unm_q[k-1];
         pipe_idx_d[k] = pipe_idx_q[k-1];
      end
      exit_idx   = pipe_idx_q[LAT-1];
      leaf_word  = out_rd_data[exit_idx*DATA_W +: DATA_W];
      rd_valid_d = pipe_vld_q[LAT-1];
      rd_data_d  = rd_data_q;
      if (pipe_vld_q[LAT-1]) begin
         if (pipe_unm_q[LAT-1])        rd_data_d = DEFAULT_RDATA;
         else if (SWAP_BYTES[exit_idx]) rd_data_d = swap_bytes(leaf_word);
         else                           rd_data_d = leaf_word;
      end
   end

   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         out_wr_q       <= '0;
         out_rd_q       <= '0;
         out_addr_q     <= '0;
         out_wr_data_q  <= '0;
         unmapped_cnt_q <= '0;
         s1_vld_q       <= 1'b0;
         s1_unm_q       <= 1'b0;
         s1_idx_q       <= '0;
         pipe_vld_q     <= '0;
         pipe_unm_q     <= '0;
         pipe_idx_q     <= '0;
         rd_valid_q     <= 1'b0;
         rd_data_q      <= '0;
      end else begin
         out_wr_q       <= out_wr_d;
         out_rd_q       <= out_rd_d;
         out_addr_q     <= out_addr_d;
         out_wr_data_q  <= out_wr_data_d;
         unmapped_cnt_q <= unmapped_cnt_d;
         s1_vld_q       <= s1_vld_d;
         s1_unm_q       <= s1_unm_d;
         s1_idx_q       <= s1_idx_d;
         pipe_vld_q     <= pipe_vld_d;
         pipe_unm_q     <= pipe_unm_d;
         pipe_idx_q     <= pipe_idx_d;
         rd_valid_q     <= rd_valid_d;
         rd_data_q      <= rd_data_d;
      end
   end

   assign out_wr         = out_wr_q;
   assign out_rd         = out_rd_q;
   assign out_addr       = out_addr_q;
   assign out_wr_data    = out_wr_data_q;
   assign unmapped_count = unmapped_cnt_q;
   assign in_rd_valid    = rd_valid_q;
   assign in_rd_data     = rd_data_q;

endmodule

// File: doc/bridge_router.md
# bridge_router

Parametrised bridge address router between the host bridge (clk_74a domain) and up to 16 leaf agents: command, dataslot, ID, ROM and further core register blocks. Routes each host read or write to exactly one leaf by address range, with a registered decode stage, optional per-leaf base stripping and byte swap, and a pipelined read-return path of fixed latency. Unmapped accesses return a default word and are counted.

## Interface
- NUM_LEAVES, 4: leaf count, 1..16
- ADDR_W, 32: address width
- DATA_W, 32: data width, multiple of 8
- ADDR_FROM, all 0: per-leaf inclusive lower bound, NUM_LEAVES×ADDR_W
- ADDR_TO, all 0: per-leaf inclusive upper bound
- STRIP_BASE, 0: NUM_LEAVES-bit mask; bit i set → leaf i sees addr−ADDR_FROM[i]
- SWAP_BYTES, 0: NUM_LEAVES-bit mask; bit i set → byte-reverse wr and rd data for leaf i
- LEAF_LATENCY, 1: cycles from leaf rd strobe to leaf rd data valid, 1..8
- DEFAULT_RDATA, 32'hFFFF_FFFF: read data returned for unmapped reads

Ports:
- clk_74a  in  1  bridge clock
- reset  in  1  asynchronous, active-high
- in_addr  in  ADDR_W  host address, valid with strobe
- in_wr  in  1  single-cycle write strobe
- in_rd  in  1  single-cycle read strobe
- in_wr_data  in  DATA_W  write data, valid with in_wr
- in_rd_data  out  DATA_W  read data, held until next read completes
- in_rd_valid  out  1  one-cycle pulse when in_rd_data updates
- out_addr  out  NUM_LEAVES×ADDR_W  per-leaf address
- out_wr  out  NUM_LEAVES  per-leaf write strobe
- out_rd  out  NUM_LEAVES  per-leaf read strobe
- out_wr_data  out  NUM_LEAVES×DATA_W  per-leaf write data
- out_rd_data  in  NUM_LEAVES×DATA_W  per-leaf read data
- unmapped_count  out  16  saturating count of unmapped or dropped accesses

## Operation
- Decode: hit[i] = ADDR_FROM[i] ≤ in_addr ≤ ADDR_TO[i], unsigned. Overlapping ranges: lowest index wins. No hit → unmapped.
- Stage 1 (registered): selected leaf gets out_wr or out_rd for one cycle; all other strobes stay 0. out_addr and out_wr_data are registered for the selected leaf only and held otherwise. Address is stripped if STRIP_BASE[i] (result ADDR_W bits, never negative given the hit). Data is byte-reversed if SWAP_BYTES[i].
- Read pipeline: shift register of depth LEAF_LATENCY carries {valid, leaf index, unmapped}. On exit, capture out_rd_data[idx] (swapped if SWAP_BYTES[idx]), or DEFAULT_RDATA if unmapped, into in_rd_data, and pulse in_rd_valid. Back-to-back reads every cycle are supported; results return in issue order.
- Unmapped write: no leaf strobe. unmapped_count += 1.
- Unmapped read: no leaf strobe. Still traverses the pipeline and returns DEFAULT_RDATA.
- in_wr and in_rd in the same cycle: write is forwarded, read is dropped (no in_rd_valid), unmapped_count += 1.
- unmapped_count saturates at 16'hFFFF.

## Timing
- Reset values: all out_wr/out_rd 0, out_addr 0, out_wr_data 0, in_rd_data 0, in_rd_valid 0, unmapped_count 0, pipeline valid bits cleared.
- Host strobe at cycle T → leaf strobe at T+1.
- Leaf data sampled at the edge ending T+1+LEAF_LATENCY. in_rd_data and in_rd_valid visible at T+2+LEAF_LATENCY; total read latency is LEAF_LATENCY+2.
- unmapped_count updates at T+1.
- Reset asserted mid-read: in-flight reads are discarded, with no in_rd_valid after reset release for reads issued before reset.

## Test plan
- NUM_LEAVES=4 with ranges f8000000–f8001fff, f8002000–f80020ff, f8002380–f80023ff, 0–00100000; write f8002004=0x12345678 → out_wr[1] at T+1, out_addr[1]=f8002004 (STRIP_BASE=0), no other strobe.
- STRIP_BASE bit1 and SWAP_BYTES bit1 set, read f8002010, leaf returns 0xAABBCCDD, LEAF_LATENCY=1 → out_addr[1]=0x10; at T+3, in_rd_data=0xDDCCBBAA and in_rd_valid pulses once.
- Read f8002200 (unmapped) → no leaf strobe; at T+3, in_rd_data=FFFFFFFF; unmapped_count=1.
- Four consecutive reads alternating leaves 0 and 3, LEAF_LATENCY=3 → four in_rd_valid pulses on consecutive cycles starting T+5, with data in issue order.
- in_wr and in_rd both high at address 0x100 → out_wr[3] only, no in_rd_valid, unmapped_count += 1. Force the counter to FFFF and repeat → stays FFFF.
- Reset asserted at T+2 during a LEAF_LATENCY=4 read → all outputs 0 immediately, no in_rd_valid after release.
